prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader that fills processor memory and starts it
//
// Receives a word count N (16-bit, high byte first) followed by N 16-bit words
// (high byte first). It writes the words to addresses 0..N-1, then pulses
// cpu_start. The optional checksum feature is enabled by defining
// LOADER_CHECKSUM_EN. With that macro defined, a trailing XOR checksum byte
// must match the XOR of every count and data byte.
//
// Ports:
//   clk        single clock
//   a_reset_n  asynchronous active-low reset
//   arm        one-cycle request to start a load (honoured in IDLE/ERROR only)
//   rx_valid   byte-stream valid
//   rx_data    byte-stream data
//   rx_ready   byte-stream ready (byte taken when rx_valid && rx_ready)
//   mem_wen    memory write strobe
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   cpu_hold   keeps the processor controller idle while not in IDLE
//   cpu_start  one-cycle start pulse after a successful load
//   err        sticky load-error flag, cleared by the next arm
module prog_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  arm,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  cpu_start,
  output logic                  err
);

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE, ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(2**ADDR_WIDTH);

  state_t                state;
  state_t                nxt;
  logic [15:0]           count;
  logic [7:0]            hi_byte;
  // One bit wider than the address so that a full-memory load can reach N.
  logic [ADDR_WIDTH:0]   addr_cnt;
  logic [16:0]           next_cnt;
  logic [15:0]           n_rx;
  logic                  take;
  logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign take      = rx_valid && rx_ready;
  assign n_rx      = {count[15:8], rx_data};
  assign next_cnt  = 17'(addr_cnt) + 17'd1;
  assign last_word = (next_cnt == {1'b0, count});

  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERROR: if (arm) nxt = CNT_HI;
      CNT_HI:      if (take) nxt = CNT_LO;
      CNT_LO: begin
        if (take) nxt = (n_rx == 16'd0 || {1'b0, n_rx} > MAX_WORDS) ? ERROR : DATA_HI;
      end
      DATA_HI:     if (take) nxt = DATA_LO;
      DATA_LO:     if (take) nxt = WRITE;
      WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        nxt = last_word ? CHECK : DATA_HI;
`else
        nxt = last_word ? DONE : DATA_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK:       if (take) nxt = (rx_data == csum) ? DONE : ERROR;
`endif
      DONE:        nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each output changes on the
  // same edge as the state it belongs to.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      cpu_start <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      hi_byte   <= '0;
      addr_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= nxt;
      rx_ready  <= (nxt == CNT_HI) || (nxt == CNT_LO) || (nxt == DATA_HI) ||
`ifdef LOADER_CHECKSUM_EN
                   (nxt == CHECK) ||
`endif
                   (nxt == DATA_LO);
      mem_wen   <= (nxt == WRITE);
      cpu_hold  <= (nxt != IDLE);
      cpu_start <= (nxt == DONE);
      // err is sticky because only arm leaves ERROR.
      err       <= (nxt == ERROR);

      case (state)
        IDLE, ERROR: begin
          if (arm) begin
            addr_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        CNT_HI:  if (take) count[15:8] <= rx_data;
        CNT_LO:  if (take) count[7:0]  <= rx_data;
        DATA_HI: if (take) hi_byte     <= rx_data;
        DATA_LO: begin
          if (take) begin
            mem_addr  <= addr_cnt[ADDR_WIDTH-1:0];
            mem_wdata <= DATA_WIDTH'({hi_byte, rx_data});
          end
        end
        WRITE:   addr_cnt <= addr_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
        default: ;
      endcase

`ifdef LOADER_CHECKSUM_EN
      // Every accepted byte except the checksum itself is folded in.
      if (take && state != CHECK) csum <= csum ^ rx_data;
`endif
    end
  end

endmodule
